id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core. It latches decoded ID-stage operands and control into the EX stage, and inserts one bubble when an instruction depends on a load currently in EX. It also squashes on branch redirect and interrupt/eret, and freezes on a downstream EX hold. Its registered `instr_ex`, `wa_ex` and `rfwr_ex` outputs drive the forwarding unit's EX-stage inputs.

## Interface
- `CTRL_W`, 16, width of the opaque EX/ME/WB control bundle
- `CNT_W`, 16, width of the bubble counter
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, asynchronous and active-low (0 = reset)
- `instr_id`  input  32  instruction word in ID
- `pc_id`  input  32  PC of ID instruction
- `rs_data_id`, `rt_data_id`  input  32 each  register-file read data
- `imm_id`  input  32  extended immediate
- `ctrl_id`  input  CTRL_W  decoded control bundle
- `rfrd_id`  input  2  bit0: reads rs; bit1: reads rt
- `wa_id`  input  5  destination register (post-mux)
- `rfwr_id`  input  1  writes register file
- `memrd_id`  input  1  is a load
- `flush_br`  input  1  taken branch/jump redirect; squash ID instruction
- `int_flush`  input  1  interrupt entry or eret; squash ID instruction
- `hold_ex`  input  1  downstream stall (EX must not advance)
- `cnt_clr`  input  1  synchronous clear of `bubble_cnt`
- `instr_ex`, `pc_ex`, `rs_data_ex`, `rt_data_ex`, `imm_ex`  output  32 each  registered copies
- `ctrl_ex`  output  CTRL_W  registered control
- `wa_ex`  output  5  registered destination
- `rfwr_ex`, `memrd_ex`, `valid_ex`  output  1 each  registered flags
- `stall_if_id`  output  1  hold PC and IF/ID register this cycle
- `bubble_cnt`  output  CNT_W  saturating count of load-use bubbles

## Operation
- Field extraction: rs = `instr_id[25:21]`, rt = `instr_id[20:16]`.
- `load_use` (combinational) asserts when all of the following hold:
  - `valid_ex`, `memrd_ex` and `rfwr_ex` are 1;
  - `wa_ex` != 0;
  - `(rfrd_id[0] & rs==wa_ex) | (rfrd_id[1] & rt==wa_ex)`.
- Per-cycle action, highest priority first:
  - 1. `int_flush`: load bubble.
  - 2. `hold_ex`: all EX registers keep their value.
  - 3. `flush_br`: load bubble.
  - 4. `load_use`: load bubble; ID instruction is held upstream.
  - 5. Otherwise: load all ID inputs; `valid_ex`=1.
- Bubble: `instr_ex`=0 (sll $0 NOP), `ctrl_ex`=0, `wa_ex`=0, `rfwr_ex`=0, `memrd_ex`=0, `valid_ex`=0. `pc_ex` loads `pc_id`, so EPC is meaningful on a squashed slot; data and imm fields are don't-care and load 0.
- On a normal load, `rfwr_ex` = `rfwr_id & (wa_id != 0)`, so $zero never triggers forwarding.
- `stall_if_id` = `hold_ex | (load_use & ~flush_br & ~int_flush)`. A flush always releases IF so fetch can redirect; a hold always freezes IF.
- `bubble_cnt`:
  - `cnt_clr` has priority and sets it to 0.
  - Otherwise +1 on each edge where action 4 is taken; saturates at all-ones.
  - Flush bubbles and holds are not counted.

## Timing
- Reset (`rst`=0), asynchronous and immediate, including mid-operation: every registered output is 0, `valid_ex`=0, `bubble_cnt`=0. `stall_if_id` then evaluates to `hold_ex`, since `valid_ex`=0 blocks `load_use`.
- Latency: ID inputs appear on the EX outputs 1 cycle after the edge they are sampled on.
- `stall_if_id` and `load_use` are combinational from the current ID inputs plus the registered EX state; no added cycle.
- Load-use costs exactly one bubble:
  - Cycle N: dependent instruction is in ID, load is in EX; `stall_if_id`=1.
  - Edge N+1: bubble enters EX; the load moves to MEM, where ME-stage forwarding resolves the dependency.
  - Cycle N+1: `load_use`=0 and the instruction advances.
- Simultaneous events:
  - `hold_ex` with `load_use`: hold wins; no bubble, no count; `load_use` is re-evaluated after the hold releases.
  - `int_flush` with `hold_ex`: bubble is loaded regardless of the hold; `stall_if_id`=1 from the hold.
  - `flush_br` with `load_use`: bubble, `stall_if_id`=0, no count.
- Back-to-back loads: a load in ID that depends on the load in EX stalls the same way; after its bubble it enters EX as a normal load.

## Test plan
- Reset: assert `rst`=0 mid-stream with nonzero EX state → all outputs 0 in the same cycle before any clock edge; `bubble_cnt`=0.
- Load-use: EX holds lw $8 (`memrd_ex`=1, `wa_ex`=8); ID has add $9,$8,$1 with `rfrd_id`=2'b11 → `stall_if_id`=1 for 1 cycle; next EX `valid_ex`=0, `instr_ex`=0; following edge `instr_ex`=add; `bubble_cnt`=1.
- No false stall: same as the load-use case but `wa_ex`=0 or `rfrd_id`=2'b00 → `stall_if_id`=0 and add advances directly. Also ID add with `wa_id`=0, `rfwr_id`=1 → `rfwr_ex`=0.
- Flush priority: `load_use` and `flush_br` both 1 → `stall_if_id`=0, bubble loaded, `bubble_cnt` unchanged; `int_flush` together with `hold_ex`=1 → bubble loaded, `stall_if_id`=1.
- Hold: `hold_ex`=1 for 3 cycles while ID inputs change → EX outputs constant, `stall_if_id`=1 each cycle; on release the ID instruction loads.
- Saturation: preload via 65535 load-use bubbles (or CNT_W=4 with 15 bubbles), then one more → `bubble_cnt` stays all-ones; `cnt_clr`=1 → 0 next edge.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// ID/EX pipeline bundle: decoded ID-stage operands/control in, registered EX-stage state out.
// The slave side belongs to the pipeline register; the master side belongs to the decode/hazard logic.
interface id_ex_pipe_if #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic [31:0]       instr_id;
  logic [31:0]       pc_id;
  logic [31:0]       rs_data_id;
  logic [31:0]       rt_data_id;
  logic [31:0]       imm_id;
  logic [CTRL_W-1:0] ctrl_id;
  logic [1:0]        rfrd_id;
  logic [4:0]        wa_id;
  logic              rfwr_id;
  logic              memrd_id;
  logic              flush_br;
  logic              int_flush;
  logic              hold_ex;
  logic              cnt_clr;

  logic [31:0]       instr_ex;
  logic [31:0]       pc_ex;
  logic [31:0]       rs_data_ex;
  logic [31:0]       rt_data_ex;
  logic [31:0]       imm_ex;
  logic [CTRL_W-1:0] ctrl_ex;
  logic [4:0]        wa_ex;
  logic              rfwr_ex;
  logic              memrd_ex;
  logic              valid_ex;
  logic              stall_if_id;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  instr_id, pc_id, rs_data_id, rt_data_id, imm_id, ctrl_id,
           rfrd_id, wa_id, rfwr_id, memrd_id,
           flush_br, int_flush, hold_ex, cnt_clr,
    output instr_ex, pc_ex, rs_data_ex, rt_data_ex, imm_ex, ctrl_ex,
           wa_ex, rfwr_ex, memrd_ex, valid_ex, stall_if_id, bubble_cnt
  );

  modport master (
    output instr_id, pc_id, rs_data_id, rt_data_id, imm_id, ctrl_id,
           rfrd_id, wa_id, rfwr_id, memrd_id,
           flush_br, int_flush, hold_ex, cnt_clr,
    input  instr_ex, pc_ex, rs_data_ex, rt_data_ex, imm_ex, ctrl_ex,
           wa_ex, rfwr_ex, memrd_ex, valid_ex, stall_if_id, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch/interrupt squash,
// downstream hold, and a saturating count of load-use bubbles.
module id_ex_pipe #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_pipe_if.slave  bus
);

  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       load_use;
  logic       take_bubble;
  logic       take_load;
  logic       lu_bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // ID stage: hazard detection against the registered EX state
  always_comb begin
    rs_id    = bus.instr_id[25:21];
    rt_id    = bus.instr_id[20:16];
    load_use = bus.valid_ex & bus.memrd_ex & bus.rfwr_ex & (bus.wa_ex != 5'd0) &
               ((bus.rfrd_id[0] & (rs_id == bus.wa_ex)) |
                (bus.rfrd_id[1] & (rt_id == bus.wa_ex)));
  end

  // int_flush overrides hold; hold overrides branch flush and load-use.
  assign take_bubble = bus.int_flush | (~bus.hold_ex & (bus.flush_br | load_use));
  assign take_load   = ~bus.int_flush & ~bus.hold_ex & ~bus.flush_br & ~load_use;
  assign lu_bubble   = ~bus.int_flush & ~bus.hold_ex & ~bus.flush_br & load_use;

  assign bus.stall_if_id = bus.hold_ex | (load_use & ~bus.flush_br & ~bus.int_flush);

  // EX stage boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.instr_ex   <= '0;
      bus.pc_ex      <= '0;
      bus.rs_data_ex <= '0;
      bus.rt_data_ex <= '0;
      bus.imm_ex     <= '0;
      bus.ctrl_ex    <= '0;
      bus.wa_ex      <= '0;
      bus.rfwr_ex    <= 1'b0;
      bus.memrd_ex   <= 1'b0;
      bus.valid_ex   <= 1'b0;
    end else if (take_bubble) begin
      // pc survives the squash so a faulting/interrupted slot still has an EPC
      bus.instr_ex   <= '0;
      bus.pc_ex      <= bus.pc_id;
      bus.rs_data_ex <= '0;
      bus.rt_data_ex <= '0;
      bus.imm_ex     <= '0;
      bus.ctrl_ex    <= '0;
      bus.wa_ex      <= '0;
      bus.rfwr_ex    <= 1'b0;
      bus.memrd_ex   <= 1'b0;
      bus.valid_ex   <= 1'b0;
    end else if (take_load) begin
      bus.instr_ex   <= bus.instr_id;
      bus.pc_ex      <= bus.pc_id;
      bus.rs_data_ex <= bus.rs_data_id;
      bus.rt_data_ex <= bus.rt_data_id;
      bus.imm_ex     <= bus.imm_id;
      bus.ctrl_ex    <= bus.ctrl_id;
      bus.wa_ex      <= bus.wa_id;
      bus.rfwr_ex    <= bus.rfwr_id & (bus.wa_id != 5'd0);
      bus.memrd_ex   <= bus.memrd_id;
      bus.valid_ex   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             bus.bubble_cnt <= '0;
    else if (bus.cnt_clr) bus.bubble_cnt <= '0;
    else if (lu_bubble)   bus.bubble_cnt <= sat_inc(bus.bubble_cnt);
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: load-use bubble, false-stall cases, flush/hold priority,
// counter saturation (4-bit counter) and asynchronous reset.
module tb_id_ex_pipe;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  localparam logic [31:0] LW8    = 32'h8C28_0000; // lw  $8,0($1)
  localparam logic [31:0] ADD    = 32'h0101_4820; // add $9,$8,$1
  localparam logic [31:0] LWSELF = 32'h8D08_0000; // lw  $8,0($8)
  localparam logic [31:0] OTHER  = 32'h0022_1820; // add $3,$1,$2

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  id_ex_pipe_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();
  id_ex_pipe #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [15:0] ctrl,
                        input logic [1:0] rfrd, input logic [4:0] wa,
                        input logic rfwr, input logic memrd);
    bus.instr_id = instr;  bus.pc_id = pc;
    bus.rs_data_id = rsd;  bus.rt_data_id = rtd;
    bus.imm_id = imm;      bus.ctrl_id = ctrl;
    bus.rfrd_id = rfrd;    bus.wa_id = wa;
    bus.rfwr_id = rfwr;    bus.memrd_id = memrd;
  endtask

  task automatic set_ctl(input logic fbr, input logic iflush, input logic hold, input logic clr);
    bus.flush_br = fbr; bus.int_flush = iflush; bus.hold_ex = hold; bus.cnt_clr = clr;
  endtask

  initial begin
    set_id('0, '0, '0, '0, '0, '0, 2'b00, 5'd0, 1'b0, 1'b0);
    set_ctl(0, 0, 0, 0);
    #2;
    chk("rst_valid", 32'(bus.valid_ex), 32'd0);
    chk("rst_cnt", 32'(bus.bubble_cnt), 32'd0);
    chk("rst_stall", 32'(bus.stall_if_id), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // load-use: lw $8 into EX, then dependent add in ID
    set_id(LW8, 32'h100, 32'h11, 32'h22, 32'h0, 16'h00A5, 2'b01, 5'd8, 1'b1, 1'b1);
    step();
    chk("lw_instr", bus.instr_ex, LW8);
    chk("lw_pc", bus.pc_ex, 32'h100);
    chk("lw_rsd", bus.rs_data_ex, 32'h11);
    chk("lw_ctrl", 32'(bus.ctrl_ex), 32'h00A5);
    chk("lw_wa", 32'(bus.wa_ex), 32'd8);
    chk("lw_flags", {29'd0, bus.rfwr_ex, bus.memrd_ex, bus.valid_ex}, 32'b111);
    set_id(ADD, 32'h104, 32'h33, 32'h44, 32'h20, 16'h0011, 2'b11, 5'd9, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(bus.stall_if_id), 32'd1);
    step();
    chk("bub_valid", 32'(bus.valid_ex), 32'd0);
    chk("bub_instr", bus.instr_ex, 32'd0);
    chk("bub_pc", bus.pc_ex, 32'h104);
    chk("bub_wa", 32'(bus.wa_ex), 32'd0);
    chk("bub_ctrl", 32'(bus.ctrl_ex), 32'd0);
    chk("bub_cnt", 32'(bus.bubble_cnt), 32'd1);
    chk("bub_stall", 32'(bus.stall_if_id), 32'd0);
    step();
    chk("adv_instr", bus.instr_ex, ADD);
    chk("adv_valid", 32'(bus.valid_ex), 32'd1);
    chk("adv_wa", 32'(bus.wa_ex), 32'd9);
    chk("adv_rtd", bus.rt_data_ex, 32'h44);

    // no false stall: load to $0 gets rfwr_ex=0
    set_id(LW8, 32'h108, 32'h1, 32'h2, 32'h0, 16'h00A5, 2'b01, 5'd0, 1'b1, 1'b1);
    step();
    chk("lw0_rfwr", 32'(bus.rfwr_ex), 32'd0);
    chk("lw0_wa", 32'(bus.wa_ex), 32'd0);
    set_id(ADD, 32'h10C, 32'h3, 32'h4, 32'h0, 16'h0011, 2'b11, 5'd9, 1'b1, 1'b0);
    #1;
    chk("wa0_stall", 32'(bus.stall_if_id), 32'd0);
    step();
    chk("wa0_instr", bus.instr_ex, ADD);
    // rfrd_id=00 never stalls
    set_id(LW8, 32'h110, 32'h1, 32'h2, 32'h0, 16'h00A5, 2'b01, 5'd8, 1'b1, 1'b1);
    step();
    set_id(ADD, 32'h114, 32'h3, 32'h4, 32'h0, 16'h0011, 2'b00, 5'd9, 1'b1, 1'b0);
    #1;
    chk("rfrd0_stall", 32'(bus.stall_if_id), 32'd0);
    step();
    chk("rfrd0_instr", bus.instr_ex, ADD);
    chk("rfrd0_cnt", 32'(bus.bubble_cnt), 32'd1);
    // add with wa_id=0, rfwr_id=1
    set_id(ADD, 32'h118, 32'h3, 32'h4, 32'h0, 16'h0011, 2'b00, 5'd0, 1'b1, 1'b0);
    step();
    chk("addwa0_rfwr", 32'(bus.rfwr_ex), 32'd0);
    chk("addwa0_valid", 32'(bus.valid_ex), 32'd1);

    // flush_br with load_use
    set_id(LW8, 32'h120, 32'h1, 32'h2, 32'h0, 16'h00A5, 2'b01, 5'd8, 1'b1, 1'b1);
    step();
    set_id(ADD, 32'h124, 32'h3, 32'h4, 32'h0, 16'h0011, 2'b11, 5'd9, 1'b1, 1'b0);
    set_ctl(1, 0, 0, 0);
    #1;
    chk("fbr_stall", 32'(bus.stall_if_id), 32'd0);
    step();
    chk("fbr_valid", 32'(bus.valid_ex), 32'd0);
    chk("fbr_instr", bus.instr_ex, 32'd0);
    chk("fbr_pc", bus.pc_ex, 32'h124);
    chk("fbr_cnt", 32'(bus.bubble_cnt), 32'd1);

    // int_flush with hold
    set_ctl(0, 0, 0, 0);
    set_id(LW8, 32'h130, 32'h1, 32'h2, 32'h0, 16'h00A5, 2'b01, 5'd8, 1'b1, 1'b1);
    step();
    set_id(ADD, 32'h134, 32'h3, 32'h4, 32'h0, 16'h0011, 2'b11, 5'd9, 1'b1, 1'b0);
    set_ctl(0, 1, 1, 0);
    #1;
    chk("iflush_stall", 32'(bus.stall_if_id), 32'd1);
    step();
    chk("iflush_valid", 32'(bus.valid_ex), 32'd0);
    chk("iflush_instr", bus.instr_ex, 32'd0);
    chk("iflush_cnt", 32'(bus.bubble_cnt), 32'd1);

    // hold for 3 cycles with changing ID inputs
    set_ctl(0, 0, 0, 0);
    set_id(ADD, 32'h140, 32'h5, 32'h6, 32'h0, 16'h0011, 2'b11, 5'd9, 1'b1, 1'b0);
    step();
    chk("pre_hold_instr", bus.instr_ex, ADD);
    set_ctl(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      set_id(LW8 + 32'(i), 32'h200 + 32'(4*i), 32'(i), 32'(i), 32'(i), 16'(i), 2'b01, 5'd7, 1'b1, 1'b1);
      #1;
      chk("hold_stall", 32'(bus.stall_if_id), 32'd1);
      step();
      chk("hold_instr", bus.instr_ex, ADD);
      chk("hold_pc", bus.pc_ex, 32'h140);
    end
    set_ctl(0, 0, 0, 0);
    set_id(OTHER, 32'h300, 32'h7, 32'h8, 32'h9, 16'h0022, 2'b11, 5'd3, 1'b1, 1'b0);
    step();
    chk("rel_instr", bus.instr_ex, OTHER);
    chk("rel_pc", bus.pc_ex, 32'h300);

    // hold beats load_use, then load_use resolves after release
    set_id(LW8, 32'h310, 32'h1, 32'h2, 32'h0, 16'h00A5, 2'b01, 5'd8, 1'b1, 1'b1);
    step();
    set_id(ADD, 32'h314, 32'h3, 32'h4, 32'h0, 16'h0011, 2'b11, 5'd9, 1'b1, 1'b0);
    set_ctl(0, 0, 1, 0);
    step();
    chk("holdlu_instr", bus.instr_ex, LW8);
    chk("holdlu_cnt", 32'(bus.bubble_cnt), 32'd1);
    set_ctl(0, 0, 0, 0);
    #1;
    chk("holdlu_stall", 32'(bus.stall_if_id), 32'd1);
    step();
    chk("holdlu_bub", 32'(bus.valid_ex), 32'd0);
    chk("holdlu_cnt2", 32'(bus.bubble_cnt), 32'd2);

    // saturation: self-dependent load produces a bubble every other cycle
    set_id(LWSELF, 32'h400, 32'h1, 32'h2, 32'h0, 16'h00A5, 2'b01, 5'd8, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step();
    chk("sat_cnt", 32'(bus.bubble_cnt), 32'd15);
    set_ctl(0, 0, 0, 1);
    step();
    chk("clr_cnt", 32'(bus.bubble_cnt), 32'd0);
    set_ctl(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    chk("post_clr_cnt", 32'(bus.bubble_cnt), 32'd2);

    // asynchronous reset mid-cycle
    set_id(OTHER, 32'h500, 32'h7, 32'h8, 32'h9, 16'h0022, 2'b11, 5'd3, 1'b1, 1'b0);
    step();
    chk("pre_rst_instr", bus.instr_ex, OTHER);
    set_ctl(0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_instr", bus.instr_ex, 32'd0);
    chk("arst_pc", bus.pc_ex, 32'd0);
    chk("arst_rsd", bus.rs_data_ex, 32'd0);
    chk("arst_ctrl", 32'(bus.ctrl_ex), 32'd0);
    chk("arst_wa", 32'(bus.wa_ex), 32'd0);
    chk("arst_flags", {29'd0, bus.rfwr_ex, bus.memrd_ex, bus.valid_ex}, 32'd0);
    chk("arst_cnt", 32'(bus.bubble_cnt), 32'd0);
    chk("arst_stall", 32'(bus.stall_if_id), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
